multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle R-type ALU decoder. Accepts one instruction (opcode + function code) per handshake. Sequences it through decode, execute, optional memory and write-back states. Drives the ALU select/shift/slt controls, the datapath muxes, the memory strobes and the register-file write enable, and supports I-type ALU and load/store instructions as well as R-type.

## Interface
- IMM_EN, 1: 1 = I-type ALU ops (addi, andi, ori, slti) legal; 0 = they decode as illegal.
- MEM_TIMEOUT, 15: max wait cycles in MEM before abort; 0 = no timeout. Counter width $clog2(MEM_TIMEOUT+1), min 1.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_valid  in  1  opcode/function_code valid
- opcode  in  6  instruction bits [31:26]
- function_code  in  6  instruction bits [5:0]
- mem_ready  in  1  memory completes access this cycle
- instr_ready  out  1  high only in IDLE
- select_bits_ALU  out  3  and 000, or 001, add 010, sub/slt 100, srl 101, sll 110, nor 111
- shift_select  out  1  shift operand path (srl, sll)
- slt_select  out  1  result = sign of subtraction (slt, slti)
- alu_src_imm  out  1  B operand = sign/zero-extended immediate
- reg_dst_rt  out  1  destination is rt (I-type, lw)
- mem_to_reg  out  1  write-back data from memory (lw)
- mem_read  out  1  lw access strobe
- mem_write  out  1  sw access strobe
- write_enable  out  1  register-file write
- illegal  out  1  one-cycle pulse: unsupported instruction
- mem_timeout  out  1  one-cycle pulse: memory abort
- state  out  3  current state (debug)

## Operation
- States: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable and return to IDLE on the next edge.
- IDLE:
  - On instr_valid, latch opcode and function_code into internal registers and go to DECODE.
  - instr_valid outside IDLE is ignored.
- DECODE:
  - Decode the latched fields. On the exit edge, update the registered controls (select_bits_ALU, shift_select, slt_select, alu_src_imm, reg_dst_rt, mem_to_reg).
  - These controls hold until the next DECODE or reset.
  - Illegal instruction: pulse illegal, go to IDLE, leave controls unchanged.
  - Otherwise go to EXEC.
- R-type decode (opcode 000000, by function_code):
  - 0x24 and; 0x25 or; 0x27 nor.
  - 0x20/0x21 add; 0x22/0x23 sub.
  - 0x2A/0x2B slt: sel 100, slt_select=1.
  - 0x02 srl and 0x00 sll: shift_select=1.
  - Any other function code is illegal.
- I-type ALU decode (IMM_EN=1), all with alu_src_imm=1 and reg_dst_rt=1:
  - 001000 addi: 010.
  - 001100 andi: 000.
  - 001101 ori: 001.
  - 001010 slti: 100, slt_select=1.
- Memory decode: alu_src_imm=1, sel 010 for both.
  - 100011 lw: reg_dst_rt=1, mem_to_reg=1.
  - 101011 sw: no register destination.
- Any other opcode is illegal.
- EXEC: one cycle. lw/sw go to MEM; all other instructions go to WB.
- MEM:
  - mem_read (lw) or mem_write (sw) stays high for every MEM cycle.
  - The wait counter clears on MEM entry and increments each cycle mem_ready=0.
  - mem_ready=1: lw goes to WB; sw goes to IDLE.
  - Counter reaches MEM_TIMEOUT with mem_ready=0 (MEM_TIMEOUT>0): pulse mem_timeout, go to IDLE, no write.
  - mem_ready wins over timeout in the same cycle.
- WB: write_enable=1 for exactly one cycle, then IDLE.
- Strobes and flags decode from the state register (Moore):
  - instr_ready = IDLE.
  - mem_read/mem_write = MEM plus the latched type.
  - write_enable = WB.
- illegal and mem_timeout are registered pulses, high the cycle after the detecting state.

## Timing
- Reset (any state, mid-access included):
  - Next edge: state=IDLE.
  - All outputs 0 except instr_ready=1; latched fields and counter cleared.
  - An in-flight mem_read/mem_write drops after that edge; no write_enable occurs.
- Handshake accepted at edge 0 (instr_valid & instr_ready).
- R-type / I-type: DECODE cycle 1, EXEC 2, WB 3 (write_enable), instr_ready again at cycle 4.
- lw with mem_ready on the k-th MEM cycle (k≥1): MEM 3..3+k-1, WB 3+k, IDLE 4+k.
- sw: IDLE at 3+k; total latency 3+k cycles.
- Illegal: illegal high in cycle 2; instr_ready high in cycle 2.
- Back-to-back: an instruction can be accepted in the first IDLE cycle after completion; no bubble beyond IDLE itself.

## Test plan
- Reset: assert reset 2 cycles from a random state -> state=0, instr_ready=1, every other output 0.
- R-type add: opcode 00, function 0x20 at cycle 0 -> select_bits_ALU=010, shift_select=0 from cycle 2; write_enable=1 only in cycle 3; instr_ready=1 in cycle 4. Repeat for sll (110, shift_select=1) and slt 0x2A (100, slt_select=1).
- lw with wait: opcode 0x23, mem_ready low 2 cycles then high -> mem_read high cycles 3–5, mem_to_reg=1, reg_dst_rt=1, write_enable in cycle 6.
- sw timeout: MEM_TIMEOUT=3, opcode 0x2B, mem_ready held 0 -> mem_write high 3 cycles, mem_timeout pulse once, write_enable never high, returns to IDLE.
- Illegal: function 0x3F; then IMM_EN=0 with addi 0x08 -> illegal pulse in cycle 2, no write_enable, previous ALU controls unchanged.
- Reset mid-MEM: lw, reset asserted in the 2nd MEM cycle -> mem_read 0 after that edge, IDLE, no write_enable; the next instruction completes normally.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, memory handshake and control outputs of multicycle_control_unit.
// The master side supplies instructions and memory completion; the slave side is the sequencer.
interface multicycle_control_unit_if;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] function_code;
  logic       mem_ready;
  logic       instr_ready;
  logic [2:0] select_bits_ALU;
  logic       shift_select;
  logic       slt_select;
  logic       alu_src_imm;
  logic       reg_dst_rt;
  logic       mem_to_reg;
  logic       mem_read;
  logic       mem_write;
  logic       write_enable;
  logic       illegal;
  logic       mem_timeout;
  logic [2:0] state;

  modport master (
    output instr_valid, opcode, function_code, mem_ready,
    input  instr_ready, select_bits_ALU, shift_select, slt_select, alu_src_imm, reg_dst_rt,
           mem_to_reg, mem_read, mem_write, write_enable, illegal, mem_timeout, state
  );

  modport slave (
    input  instr_valid, opcode, function_code, mem_ready,
    output instr_ready, select_bits_ALU, shift_select, slt_select, alu_src_imm, reg_dst_rt,
           mem_to_reg, mem_read, mem_write, write_enable, illegal, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC -> [MEM] -> WB for R-type,
// I-type ALU and load/store instructions, with registered ALU/datapath controls.
module multicycle_control_unit #(
  parameter bit          IMM_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                       clock,
  input logic                       reset,
  multicycle_control_unit_if.slave  bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Abort fires on the MEM cycle whose increment would make the count reach MEM_TIMEOUT.
  localparam logic [CntW-1:0] CntLast = CntW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]      state_q, state_d;
  logic [5:0]      opc_q, opc_d;
  logic [5:0]      fn_q, fn_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            shift_q, shift_d;
  logic            slt_q, slt_d;
  logic            imm_q, imm_d;
  logic            rt_q, rt_d;
  logic            m2r_q, m2r_d;
  logic            illegal_q, illegal_d;
  logic            tmo_q, tmo_d;

  logic       dec_ok;
  logic [2:0] dec_sel;
  logic       dec_shift, dec_slt, dec_imm, dec_rt, dec_m2r;
  logic       is_lw, is_sw;

  assign is_lw = (opc_q == OpLw);
  assign is_sw = (opc_q == OpSw);

  always_comb begin
    dec_ok    = 1'b1;
    dec_sel   = 3'b010;
    dec_shift = 1'b0;
    dec_slt   = 1'b0;
    dec_imm   = 1'b0;
    dec_rt    = 1'b0;
    dec_m2r   = 1'b0;
    case (opc_q)
      OpRtype: begin
        case (fn_q)
          6'h24:        dec_sel = 3'b000;
          6'h25:        dec_sel = 3'b001;
          6'h27:        dec_sel = 3'b111;
          6'h20, 6'h21: dec_sel = 3'b010;
          6'h22, 6'h23: dec_sel = 3'b100;
          6'h2A, 6'h2B: begin dec_sel = 3'b100; dec_slt = 1'b1; end
          6'h02:        begin dec_sel = 3'b101; dec_shift = 1'b1; end
          6'h00:        begin dec_sel = 3'b110; dec_shift = 1'b1; end
          default:      dec_ok = 1'b0;
        endcase
      end
      OpAddi, OpAndi, OpOri, OpSlti: begin
        dec_ok  = IMM_EN;
        dec_imm = 1'b1;
        dec_rt  = 1'b1;
        case (opc_q)
          OpAndi:  dec_sel = 3'b000;
          OpOri:   dec_sel = 3'b001;
          OpSlti:  begin dec_sel = 3'b100; dec_slt = 1'b1; end
          default: dec_sel = 3'b010;
        endcase
      end
      OpLw: begin
        dec_imm = 1'b1;
        dec_rt  = 1'b1;
        dec_m2r = 1'b1;
      end
      OpSw:    dec_imm = 1'b1;
      default: dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    fn_d      = fn_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    shift_d   = shift_q;
    slt_d     = slt_q;
    imm_d     = imm_q;
    rt_d      = rt_q;
    m2r_d     = m2r_q;
    illegal_d = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          opc_d   = bus.opcode;
          fn_d    = bus.function_code;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!dec_ok) begin
          illegal_d = 1'b1;
          state_d   = StIdle;
        end else begin
          sel_d   = dec_sel;
          shift_d = dec_shift;
          slt_d   = dec_slt;
          imm_d   = dec_imm;
          rt_d    = dec_rt;
          m2r_d   = dec_m2r;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d   = '0;
        state_d = (is_lw || is_sw) ? StMem : StWb;
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d = is_lw ? StWb : StIdle;
        end else if ((MEM_TIMEOUT > 0) && (cnt_q == CntLast)) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      opc_q     <= '0;
      fn_q      <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      shift_q   <= 1'b0;
      slt_q     <= 1'b0;
      imm_q     <= 1'b0;
      rt_q      <= 1'b0;
      m2r_q     <= 1'b0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      fn_q      <= fn_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      shift_q   <= shift_d;
      slt_q     <= slt_d;
      imm_q     <= imm_d;
      rt_q      <= rt_d;
      m2r_q     <= m2r_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.instr_ready     = (state_q == StIdle);
  assign bus.mem_read        = (state_q == StMem) && is_lw;
  assign bus.mem_write       = (state_q == StMem) && is_sw;
  assign bus.write_enable    = (state_q == StWb);
  assign bus.select_bits_ALU = sel_q;
  assign bus.shift_select    = shift_q;
  assign bus.slt_select      = slt_q;
  assign bus.alu_src_imm     = imm_q;
  assign bus.reg_dst_rt      = rt_q;
  assign bus.mem_to_reg      = m2r_q;
  assign bus.illegal         = illegal_q;
  assign bus.mem_timeout     = tmo_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: dut0 has I-type enabled and a 3-cycle memory timeout, dut1 has I-type
// disabled and no timeout; both see identical stimulus.
module tb_multicycle_control_unit;

  logic clock;
  logic reset;

  multicycle_control_unit_if bus0 ();
  multicycle_control_unit_if bus1 ();

  multicycle_control_unit #(.IMM_EN(1'b1), .MEM_TIMEOUT(3)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  multicycle_control_unit #(.IMM_EN(1'b0), .MEM_TIMEOUT(0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f, input logic r);
    bus0.instr_valid   = v;
    bus0.opcode        = o;
    bus0.function_code = f;
    bus0.mem_ready     = r;
    bus1.instr_valid   = v;
    bus1.opcode        = o;
    bus1.function_code = f;
    bus1.mem_ready     = r;
  endtask

  // {sel, shift, slt, alu_src_imm, reg_dst_rt, mem_to_reg}
  function automatic logic [15:0] ctrl0();
    return {8'h00, bus0.select_bits_ALU, bus0.shift_select, bus0.slt_select, bus0.alu_src_imm,
            bus0.reg_dst_rt, bus0.mem_to_reg};
  endfunction

  function automatic logic [15:0] ctrl1();
    return {8'h00, bus1.select_bits_ALU, bus1.shift_select, bus1.slt_select, bus1.alu_src_imm,
            bus1.reg_dst_rt, bus1.mem_to_reg};
  endfunction

  // Every output except instr_ready and state.
  function automatic logic [15:0] outs0();
    return {3'b000, bus0.select_bits_ALU, bus0.shift_select, bus0.slt_select, bus0.alu_src_imm,
            bus0.reg_dst_rt, bus0.mem_to_reg, bus0.mem_read, bus0.mem_write, bus0.write_enable,
            bus0.illegal, bus0.mem_timeout};
  endfunction

  // Non-memory instruction on dut0: handshake at edge 0, checks cycles 1..4.
  task automatic run_alu(input string tag, input logic [5:0] o, input logic [5:0] f,
                         input logic [7:0] exp_ctrl);
    drive(1'b1, o, f, 1'b0);
    tick();
    chk({tag, "_c1_state"}, {13'd0, bus0.state}, 16'd1);
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();
    chk({tag, "_c2_ctrl"}, ctrl0(), {8'h00, exp_ctrl});
    chk({tag, "_c2_we"}, {15'd0, bus0.write_enable}, 16'd0);
    tick();
    chk({tag, "_c3_we"}, {15'd0, bus0.write_enable}, 16'd1);
    chk({tag, "_c3_rdy"}, {15'd0, bus0.instr_ready}, 16'd0);
    tick();
    chk({tag, "_c4_rdy"}, {15'd0, bus0.instr_ready}, 16'd1);
    chk({tag, "_c4_we"}, {15'd0, bus0.write_enable}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
    tick();
    tick();
    chk("rst_state", {13'd0, bus0.state}, 16'd0);
    chk("rst_rdy", {15'd0, bus0.instr_ready}, 16'd1);
    chk("rst_outs", outs0(), 16'd0);
    reset = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();

    run_alu("add", 6'h00, 6'h20, 8'b010_0_0_0_0_0);
    run_alu("sll", 6'h00, 6'h00, 8'b110_1_0_0_0_0);
    run_alu("slt", 6'h00, 6'h2A, 8'b100_0_1_0_0_0);
    run_alu("nor", 6'h00, 6'h27, 8'b111_0_0_0_0_0);
    run_alu("ori", 6'h0D, 6'h15, 8'b001_0_0_1_1_0);

    // lw, mem_ready on the 3rd MEM cycle
    drive(1'b1, 6'h23, 6'h00, 1'b0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();
    chk("lw_c2_rd", {15'd0, bus0.mem_read}, 16'd0);
    chk("lw_c2_ctrl", ctrl0(), 16'b010_0_0_1_1_1);
    tick();
    chk("lw_c3_rd", {15'd0, bus0.mem_read}, 16'd1);
    tick();
    chk("lw_c4_rd", {15'd0, bus0.mem_read}, 16'd1);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b1);
    chk("lw_c5_rd", {15'd0, bus0.mem_read}, 16'd1);
    chk("lw_c5_we", {15'd0, bus0.write_enable}, 16'd0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    chk("lw_c6_we", {15'd0, bus0.write_enable}, 16'd1);
    chk("lw_c6_rd", {15'd0, bus0.mem_read}, 16'd0);
    chk("lw_c6_we_b", {15'd0, bus1.write_enable}, 16'd1);
    tick();
    chk("lw_c7_rdy", {15'd0, bus0.instr_ready}, 16'd1);

    // sw with mem_ready held low: dut0 aborts after 3 MEM cycles, dut1 waits
    drive(1'b1, 6'h2B, 6'h00, 1'b0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();
    tick();
    chk("sw_c3_wr", {15'd0, bus0.mem_write}, 16'd1);
    tick();
    chk("sw_c4_wr", {15'd0, bus0.mem_write}, 16'd1);
    tick();
    chk("sw_c5_wr", {15'd0, bus0.mem_write}, 16'd1);
    chk("sw_c5_tmo", {15'd0, bus0.mem_timeout}, 16'd0);
    tick();
    chk("sw_c6_tmo", {15'd0, bus0.mem_timeout}, 16'd1);
    chk("sw_c6_wr", {15'd0, bus0.mem_write}, 16'd0);
    chk("sw_c6_state", {13'd0, bus0.state}, 16'd0);
    chk("sw_c6_we", {15'd0, bus0.write_enable}, 16'd0);
    chk("sw_c6_b_wr", {15'd0, bus1.mem_write}, 16'd1);
    chk("sw_c6_b_tmo", {15'd0, bus1.mem_timeout}, 16'd0);
    drive(1'b0, 6'h00, 6'h00, 1'b1);
    tick();
    chk("sw_c7_tmo", {15'd0, bus0.mem_timeout}, 16'd0);
    chk("sw_c7_b_state", {13'd0, bus1.state}, 16'd0);
    chk("sw_c7_b_we", {15'd0, bus1.write_enable}, 16'd0);
    drive(1'b0, 6'h00, 6'h00, 1'b0);

    // Illegal R-type function: controls keep the sw decode
    drive(1'b1, 6'h00, 6'h3F, 1'b0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    chk("ill_c1_pulse", {15'd0, bus0.illegal}, 16'd0);
    tick();
    chk("ill_c2_pulse", {15'd0, bus0.illegal}, 16'd1);
    chk("ill_c2_rdy", {15'd0, bus0.instr_ready}, 16'd1);
    chk("ill_c2_ctrl", ctrl0(), 16'b010_0_0_1_0_0);
    tick();
    chk("ill_c3_pulse", {15'd0, bus0.illegal}, 16'd0);
    chk("ill_c3_we", {15'd0, bus0.write_enable}, 16'd0);

    // addi: legal on dut0, illegal on dut1
    drive(1'b1, 6'h08, 6'h00, 1'b0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();
    chk("addi_c2_ctrl", ctrl0(), 16'b010_0_0_1_1_0);
    chk("addi_c2_ill", {15'd0, bus0.illegal}, 16'd0);
    chk("addi_b_ill", {15'd0, bus1.illegal}, 16'd1);
    chk("addi_b_ctrl", ctrl1(), 16'b010_0_0_1_0_0);
    chk("addi_b_rdy", {15'd0, bus1.instr_ready}, 16'd1);
    tick();
    chk("addi_c3_we", {15'd0, bus0.write_enable}, 16'd1);
    chk("addi_b_we", {15'd0, bus1.write_enable}, 16'd0);
    tick();

    // Reset during the 2nd MEM cycle of a lw
    drive(1'b1, 6'h23, 6'h00, 1'b0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    tick();
    tick();
    chk("rmem_c3_rd", {15'd0, bus0.mem_read}, 16'd1);
    tick();
    chk("rmem_c4_rd", {15'd0, bus0.mem_read}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmem_state", {13'd0, bus0.state}, 16'd0);
    chk("rmem_rdy", {15'd0, bus0.instr_ready}, 16'd1);
    chk("rmem_outs", outs0(), 16'd0);
    tick();
    chk("rmem_we", {15'd0, bus0.write_enable}, 16'd0);
    run_alu("post_rst_sub", 6'h00, 6'h22, 8'b100_0_0_0_0_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
